// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-glyph lookup for the seven-segment scan driver.
// Glyphs are active-low: bit0 = segment a ... bit6 = segment g.
package seven_seg_pkg;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Lowercase b and d keep 8/B and 0/D distinguishable on the display.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = GLYPH_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_segment_glyph.sv
// Combinational 4-bit to active-low 7-segment decoder.
module seven_segment_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit common-anode driver: shadow-registered hex value,
// programmable refresh prescaler, leading-zero blanking, registered outputs.
module seven_segment_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIVIDE     = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              segment,
   output logic                    dp
);

   localparam int PW = $clog2(DIVIDE);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int NW = 4 * NUM_DIGITS;

   localparam logic [PW-1:0] PRESC_MAX = PW'(DIVIDE - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NW-1:0]         value_q, value_d;
   logic [NUM_DIGITS-1:0] dpin_q, dpin_d;
   logic                  lz_q, lz_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [6:0]            segment_q, segment_d;
   logic                  dp_q, dp_d;

   logic [NUM_DIGITS-1:0] blank_mask;
   logic                  zero_above;
   logic [3:0]            cur_nibble;
   logic [6:0]            cur_glyph;

   // Digit k blanks when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      blank_mask = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above    = zero_above & (value_q[4*k +: 4] == 4'h0);
         blank_mask[k] = lz_q & zero_above;
      end
   end

   assign cur_nibble = value_q[4*int'(idx_q) +: 4];

   seven_segment_glyph u_glyph (
      .nibble (cur_nibble),
      .seg    (cur_glyph)
   );

   always_comb begin
      value_d   = value_q;
      dpin_d    = dpin_q;
      lz_d      = lz_q;
      presc_d   = presc_q;
      idx_d     = idx_q;
      anode_d   = ANODE_OFF;
      segment_d = SEG_OFF;
      dp_d      = 1'b1;

      // The whole shadow updates in one edge so a digit never shows a torn value.
      if (load) begin
         value_d = value;
         dpin_d  = dp_in;
         lz_d    = lz_blank;
      end

      if (!enable) begin
         presc_d = '0;
         idx_d   = '0;
      end else begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end

         if (!blank_mask[idx_q]) begin
            anode_d   = ~(ONE_HOT0 << idx_q);
            segment_d = cur_glyph;
            dp_d      = ~dpin_q[idx_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         idx_q     <= '0;
         value_q   <= '0;
         dpin_q    <= '0;
         lz_q      <= 1'b0;
         anode_q   <= ANODE_OFF;
         segment_q <= SEG_OFF;
         dp_q      <= 1'b1;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         value_q   <= value_d;
         dpin_q    <= dpin_d;
         lz_q      <= lz_d;
         anode_q   <= anode_d;
         segment_q <= segment_d;
         dp_q      <= dp_d;
      end
   end

   assign anode   = anode_q;
   assign segment = segment_q;
   assign dp      = dp_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with NUM_DIGITS=4, DIVIDE=4.
module tb_seven_segment_scan;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        lz_blank;
   logic [3:0]  anode;
   logic [6:0]  segment;
   logic        dp;

   int n_cmp = 0;
   int n_bad = 0;

   seven_segment_scan #(
      .NUM_DIGITS (4),
      .DIVIDE     (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .load     (load),
      .value    (value),
      .dp_in    (dp_in),
      .lz_blank (lz_blank),
      .anode    (anode),
      .segment  (segment),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] exp_an,
                        input logic [6:0] exp_seg, input logic exp_dp);
      n_cmp++;
      assert ({anode, segment, dp} === {exp_an, exp_seg, exp_dp})
      else begin
         n_bad++;
         $error("FAIL %s: got anode=%h seg=%h dp=%b, want anode=%h seg=%h dp=%b",
                tag, anode, segment, dp, exp_an, exp_seg, exp_dp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_check(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp);
      tick();
      check(tag, exp_an, exp_seg, exp_dp);
   endtask

   task automatic expect_slot(input string tag, input int cycles, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg, input logic exp_dp);
      for (int i = 0; i < cycles; i++) tick_check(tag, exp_an, exp_seg, exp_dp);
   endtask

   // Disable for one edge while loading, then re-enable so the next edge starts digit 0.
   task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic lz);
      enable   = 1'b0;
      load     = 1'b1;
      value    = v;
      dp_in    = d;
      lz_blank = lz;
      tick_check("restart_dark", 4'hF, 7'h7F, 1'b1);
      load   = 1'b0;
      value  = $urandom_range(0, 65535);
      dp_in  = 4'($urandom_range(0, 15));
      enable = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      value    = 16'h0;
      dp_in    = 4'h0;
      lz_blank = 1'b0;

      // Reset and idle
      #3 rst_n = 1'b0;
      #1 check("reset_async", 4'hF, 7'h7F, 1'b1);
      tick_check("reset_held", 4'hF, 7'h7F, 1'b1);
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      expect_slot("idle_d0", 4, 4'hE, 7'h40, 1'b1);
      expect_slot("idle_d1", 4, 4'hD, 7'h40, 1'b1);
      expect_slot("idle_d2", 4, 4'hB, 7'h40, 1'b1);
      expect_slot("idle_d3", 4, 4'h7, 7'h40, 1'b1);
      expect_slot("idle_wrap", 1, 4'hE, 7'h40, 1'b1);

      // Hex scan
      restart(16'h12AF, 4'b0000, 1'b0);
      expect_slot("hex_d0", 4, 4'hE, 7'h0E, 1'b1);
      expect_slot("hex_d1", 4, 4'hD, 7'h08, 1'b1);
      expect_slot("hex_d2", 4, 4'hB, 7'h24, 1'b1);
      expect_slot("hex_d3", 4, 4'h7, 7'h79, 1'b1);
      expect_slot("hex_wrap", 4, 4'hE, 7'h0E, 1'b1);

      // Leading-zero blank
      restart(16'h0050, 4'b0000, 1'b1);
      expect_slot("lz_d0", 4, 4'hE, 7'h40, 1'b1);
      expect_slot("lz_d1", 4, 4'hD, 7'h12, 1'b1);
      expect_slot("lz_d2", 4, 4'hF, 7'h7F, 1'b1);
      expect_slot("lz_d3", 4, 4'hF, 7'h7F, 1'b1);
      expect_slot("lz_wrap", 1, 4'hE, 7'h40, 1'b1);

      restart(16'h0000, 4'b1001, 1'b1);
      expect_slot("lz0_d0", 4, 4'hE, 7'h40, 1'b0);
      expect_slot("lz0_d1", 4, 4'hF, 7'h7F, 1'b1);
      expect_slot("lz0_d2", 4, 4'hF, 7'h7F, 1'b1);
      expect_slot("lz0_d3", 4, 4'hF, 7'h7F, 1'b1);

      // Decimal point
      restart(16'h12AF, 4'b0100, 1'b0);
      expect_slot("dp_d0", 4, 4'hE, 7'h0E, 1'b1);
      expect_slot("dp_d1", 4, 4'hD, 7'h08, 1'b1);
      expect_slot("dp_d2", 4, 4'hB, 7'h24, 1'b0);
      expect_slot("dp_d3", 4, 4'h7, 7'h79, 1'b1);

      // Load mid-slot: strobe sampled on the 3rd edge of slot 0, new glyph on the 4th
      restart(16'h12AF, 4'b0000, 1'b0);
      expect_slot("ldmid_pre", 2, 4'hE, 7'h0E, 1'b1);
      load  = 1'b1;
      value = 16'h3456;
      dp_in = 4'b0000;
      tick_check("ldmid_strobe", 4'hE, 7'h0E, 1'b1);
      load = 1'b0;
      tick_check("ldmid_new", 4'hE, 7'h02, 1'b1);
      expect_slot("ldmid_d1", 4, 4'hD, 7'h12, 1'b1);
      expect_slot("ldmid_d2", 4, 4'hB, 7'h19, 1'b1);
      expect_slot("ldmid_d3", 3, 4'h7, 7'h30, 1'b1);

      // Load on the wrap edge: new data lands with digit 0
      load  = 1'b1;
      value = 16'h789A;
      tick_check("ldwrap_strobe", 4'h7, 7'h30, 1'b1);
      load = 1'b0;
      expect_slot("ldwrap_d0", 4, 4'hE, 7'h08, 1'b1);
      expect_slot("ldwrap_d1", 4, 4'hD, 7'h10, 1'b1);

      // Enable dropped mid-slot 2, then re-enabled
      expect_slot("en_d2", 2, 4'hB, 7'h00, 1'b1);
      enable = 1'b0;
      expect_slot("en_dark", 2, 4'hF, 7'h7F, 1'b1);
      enable = 1'b1;
      expect_slot("en_restart", 4, 4'hE, 7'h08, 1'b1);
      expect_slot("en_next", 2, 4'hD, 7'h10, 1'b1);

      // Reset mid-scan clears the shadow
      rst_n = 1'b0;
      #1 check("rst_mid_async", 4'hF, 7'h7F, 1'b1);
      tick_check("rst_mid_held", 4'hF, 7'h7F, 1'b1);
      rst_n = 1'b1;
      expect_slot("rst_d0", 4, 4'hE, 7'h40, 1'b1);
      expect_slot("rst_d1", 4, 4'hD, 7'h40, 1'b1);
      expect_slot("rst_d2", 4, 4'hB, 7'h40, 1'b1);
      expect_slot("rst_d3", 4, 4'h7, 7'h40, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
